tone_route_sequencer: RTL

Junction decision scheduler between the tone detector and the Drive block. While Drive holds `enableToneDetection` high at a junction, this block votes over per-tone hit strobes from the detector. It issues one registered `toneDir` command, or a fallback command on timeout, and returns to `TD_HOLD` when Drive drops the enable. It is the only source of `toneDir` for Drive.

---
 rtl/tone_route_sequencer_pkg.sv | 35 +++
 rtl/tone_vote_counter.sv | 34 +++
 rtl/tone_route_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tone_route_sequencer_pkg.sv
// Shared codes for the junction tone sequencer: Drive commands, FSM states,
// toneHit bit positions and the tone priority encoder.
package tone_route_sequencer_pkg;

    localparam logic [2:0] TD_HOLD     = 3'd0;
    localparam logic [2:0] TD_STRAIGHT = 3'd1;
    localparam logic [2:0] TD_LEFT     = 3'd2;
    localparam logic [2:0] TD_RIGHT    = 3'd3;
    localparam logic [2:0] TD_BACK     = 3'd4;
    localparam logic [2:0] TD_STOP     = 3'd5;

    localparam int unsigned NUM_TONES     = 5;
    localparam int unsigned TONE_STRAIGHT = 0;
    localparam int unsigned TONE_LEFT     = 1;
    localparam int unsigned TONE_RIGHT    = 2;
    localparam int unsigned TONE_BACK     = 3;
    localparam int unsigned TONE_STOP     = 4;

    typedef enum logic [1:0] {
        TS_IDLE    = 2'd0,
        TS_LISTEN  = 2'd1,
        TS_DECIDED = 2'd2
    } ts_state_e;

    // STOP > BACK > RIGHT > LEFT > STRAIGHT; TD_HOLD when nothing is set.
    function automatic logic [2:0] tone_priority(input logic [NUM_TONES-1:0] hits);
        if (hits[TONE_STOP])          return TD_STOP;
        else if (hits[TONE_BACK])     return TD_BACK;
        else if (hits[TONE_RIGHT])    return TD_RIGHT;
        else if (hits[TONE_LEFT])     return TD_LEFT;
        else if (hits[TONE_STRAIGHT]) return TD_STRAIGHT;
        return TD_HOLD;
    endfunction

endpackage

// File: rtl/tone_vote_counter.sv
// Per-tone hit counter for one voting window; flags the strobe whose
// increment brings the count up to THRESH.
module tone_vote_counter
    import tone_route_sequencer_pkg::*;
#(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned THRESH = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         inc,
    output logic [$clog2(WINDOW+1)-1:0]  count,
    output logic                         atThresh
);

    localparam int unsigned CW = $clog2(WINDOW + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != CW'(WINDOW))) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign count    = count_q;
    assign atThresh = inc && (count_q == CW'(THRESH - 1));

endmodule

// File: rtl/tone_route_sequencer.sv
// Junction decision scheduler: votes over detector tone strobes while Drive
// enables detection and issues one registered toneDir command (or a fallback).
module tone_route_sequencer
    import tone_route_sequencer_pkg::*;
#(
    parameter int unsigned WINDOW   = 16,
    parameter int unsigned THRESH   = 10,
    parameter int unsigned TIMEOUT  = 50_000_000,
    parameter logic [2:0]  FALLBACK = TD_STRAIGHT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       sampleStrobe,
    input  logic [4:0] toneHit,
    output logic [2:0] toneDir,
    output logic       decided,
    output logic       timedOut,
    output logic [7:0] junctionCount
);

    localparam int unsigned CW = $clog2(WINDOW + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    ts_state_e      state_q, state_d;
    logic [2:0]     tone_dir_q, tone_dir_d;
    logic           timed_out_q, timed_out_d;
    logic [7:0]     junction_q, junction_d;
    logic [CW-1:0]  sample_q, sample_d;
    logic [TW-1:0]  timeout_q, timeout_d;

    logic                  vote_clear;
    logic [NUM_TONES-1:0]  vote_inc;
    logic [NUM_TONES-1:0]  at_thresh;
    logic [CW-1:0]         vote_count [NUM_TONES];
    logic                  listening;

    assign listening = (state_q == TS_LISTEN) && enable;
    assign vote_inc  = (listening && sampleStrobe) ? toneHit : '0;

    for (genvar i = 0; i < NUM_TONES; i++) begin : g_vote
        tone_vote_counter #(
            .WINDOW (WINDOW),
            .THRESH (THRESH)
        ) u_vote (
            .clk      (clk),
            .rst      (rst),
            .clear    (vote_clear),
            .inc      (vote_inc[i]),
            .count    (vote_count[i]),
            .atThresh (at_thresh[i])
        );

        assert property (@(posedge clk) disable iff (!rst) vote_count[i] <= CW'(WINDOW));
    end

    always_comb begin
        state_d     = state_q;
        tone_dir_d  = tone_dir_q;
        timed_out_d = timed_out_q;
        junction_d  = junction_q;
        sample_d    = sample_q;
        timeout_d   = timeout_q;
        vote_clear  = 1'b1;

        unique case (state_q)
            TS_IDLE: begin
                tone_dir_d = TD_HOLD;
                sample_d   = '0;
                timeout_d  = '0;
                if (enable) begin
                    state_d     = TS_LISTEN;
                    timed_out_d = 1'b0;
                end
            end
            TS_LISTEN: begin
                if (!enable) begin
                    // Abort wins over any decision or timeout on this cycle.
                    state_d    = TS_IDLE;
                    tone_dir_d = TD_HOLD;
                    sample_d   = '0;
                    timeout_d  = '0;
                end else begin
                    vote_clear = 1'b0;
                    timeout_d  = timeout_q + TW'(1);
                    if (sampleStrobe) begin
                        sample_d = sample_q + CW'(1);
                    end
                    if (|at_thresh) begin
                        state_d    = TS_DECIDED;
                        tone_dir_d = tone_priority(at_thresh);
                        junction_d = junction_q + 8'd1;
                    end else if (timeout_q == TW'(TIMEOUT - 1)) begin
                        state_d     = TS_DECIDED;
                        tone_dir_d  = FALLBACK;
                        timed_out_d = 1'b1;
                        junction_d  = junction_q + 8'd1;
                    end else if (sampleStrobe && (sample_q == CW'(WINDOW - 1))) begin
                        vote_clear = 1'b1;
                        sample_d   = '0;
                    end
                end
            end
            TS_DECIDED: begin
                if (!enable) begin
                    state_d    = TS_IDLE;
                    tone_dir_d = TD_HOLD;
                end
            end
            default: begin
                state_d    = TS_IDLE;
                tone_dir_d = TD_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= TS_IDLE;
            tone_dir_q  <= TD_HOLD;
            timed_out_q <= 1'b0;
            junction_q  <= 8'd0;
            sample_q    <= '0;
            timeout_q   <= '0;
        end else begin
            state_q     <= state_d;
            tone_dir_q  <= tone_dir_d;
            timed_out_q <= timed_out_d;
            junction_q  <= junction_d;
            sample_q    <= sample_d;
            timeout_q   <= timeout_d;
        end
    end

    assign toneDir       = tone_dir_q;
    assign decided       = (state_q == TS_DECIDED);
    assign timedOut      = timed_out_q;
    assign junctionCount = junction_q;

endmodule
